// File: rtl/reg8x32_access_ctrl.sv
// reg8x32_access_ctrl: in-order command FIFO and sequencer driving register_file_8_32.
// Define CLEAR_ON_RESET_EN to zero every register after reset before accepting commands.
module reg8x32_access_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_ce,
    output logic [DATA_W-1:0] rf_di,
    input  logic [DATA_W-1:0] rf_do,
    output logic              busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {IDLE, WR, RD, RESP, INIT} state_t;

    state_t            state;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              push, pop;
`ifdef CLEAR_ON_RESET_EN
    logic [ADDR_W:0]   init_cnt;
`endif

    // Ready comes from registered state only, so a same-cycle pop never frees a slot.
    assign req_ready = count != CW'(FIFO_DEPTH) && state != INIT;
    assign push      = req_valid && req_ready;
    assign pop       = state == IDLE && count != '0;
    assign busy      = count != '0 || state != IDLE;
    assign head      = mem[rp];

    always_ff @(posedge clk)
        if (push) mem[wp] <= {req_we, req_addr, req_wdata};

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end

    // rf_addr/rf_di double as the command register; they hold between commands.
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
`ifdef CLEAR_ON_RESET_EN
            state    <= INIT;
            init_cnt <= '0;
`else
            state    <= IDLE;
`endif
            rf_ce     <= 1'b0;
            rf_addr   <= '0;
            rf_di     <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            rf_ce <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    rf_addr <= head[DATA_W +: ADDR_W];
                    if (head[EW-1]) begin
                        rf_di <= head[DATA_W-1:0];
                        rf_ce <= 1'b1;
                        state <= WR;
                    end else state <= RD;
                end
                WR: state <= IDLE;
                RD: begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= rf_addr;
                    rsp_rdata <= rf_do;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
`ifdef CLEAR_ON_RESET_EN
                INIT: if (init_cnt[ADDR_W]) state <= IDLE;
                else begin
                    rf_ce    <= 1'b1;
                    rf_addr  <= init_cnt[ADDR_W-1:0];
                    rf_di    <= '0;
                    init_cnt <= init_cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_reg8x32_access_ctrl.sv
// tb_reg8x32_access_ctrl: randomized bench with a register-file model and an in-order reference model.
module tb_reg8x32_access_ctrl;
    logic        clk = 0, clr = 0, req_valid = 0, req_we = 0, rsp_ready = 1;
    logic [2:0]  req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, rsp_valid, rf_ce, busy;
    logic [2:0]  rsp_addr, rf_addr;
    logic [31:0] rsp_rdata, rf_di, rf_do;

    reg8x32_access_ctrl dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_rdata(rsp_rdata), .rf_addr(rf_addr), .rf_ce(rf_ce), .rf_di(rf_di),
        .rf_do(rf_do), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] rf_mem [8];
    always @(posedge clk) if (rf_ce) rf_mem[rf_addr] <= rf_di;
    assign rf_do = rf_mem[rf_addr];

    logic [31:0] ref_mem [8];
    logic [34:0] exp_rsp[$], exp_wr[$], rcv[$], wr_log[$];
    int          wr_cyc[$];
    int          n_checks = 0, n_fail = 0, cyc = 0;
    bit          chk_wr = 1, rand_rdy = 0, hold_p = 0;
    logic [34:0] hold_v;

    always @(posedge clk) cyc++;

    // Reference model: memory image updated at acceptance, responses and writes expected in order.
    always @(negedge clk)
        if (!clr) hold_p = 0;
        else begin
            if (req_valid && req_ready) begin
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                    exp_wr.push_back({req_addr, req_wdata});
                end else exp_rsp.push_back({req_addr, ref_mem[req_addr]});
            end
            if (rf_ce) begin
                wr_log.push_back({rf_addr, rf_di});
                wr_cyc.push_back(cyc);
                if (chk_wr) begin
                    n_checks++;
                    if (exp_wr.size() == 0 || exp_wr[0] !== {rf_addr, rf_di}) begin
                        n_fail++;
                        $display("FAIL write_order: got addr=%0d data=%h, required %h (pending %0d)",
                                 rf_addr, rf_di, exp_wr.size() ? exp_wr[0] : 35'h0, exp_wr.size());
                    end
                    if (exp_wr.size() != 0) void'(exp_wr.pop_front());
                end
            end
            if (hold_p) begin
                n_checks++;
                if (!rsp_valid || {rsp_addr, rsp_rdata} !== hold_v) begin
                    n_fail++;
                    $display("FAIL rsp_hold: got valid=%b %h, required valid=1 %h", rsp_valid, {rsp_addr, rsp_rdata}, hold_v);
                end
            end
            hold_p = rsp_valid && !rsp_ready;
            hold_v = {rsp_addr, rsp_rdata};
            if (rsp_valid && rsp_ready) begin
                rcv.push_back({rsp_addr, rsp_rdata});
                n_checks++;
                if (exp_rsp.size() == 0 || exp_rsp[0] !== {rsp_addr, rsp_rdata}) begin
                    n_fail++;
                    $display("FAIL response: got addr=%0d data=%h, required %h (pending %0d)",
                             rsp_addr, rsp_rdata, exp_rsp.size() ? exp_rsp[0] : 35'h0, exp_rsp.size());
                end
                if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
            end
        end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) rsp_ready = $urandom_range(0, 2) != 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input bit we, input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && n < 200) begin tick(); n++; end
        n_checks++;
        if (n == 200) begin
            n_fail++;
            $display("FAIL send_timeout: req_ready=%b, required 1 within 200 cycles", req_ready);
        end
        tick();
        req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1;
        while ((busy || rsp_valid) && n < 500) begin tick(); n++; end
        n_checks++;
        if (busy || rsp_valid || exp_rsp.size() != 0 || exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL drain: busy=%b rsp_valid=%b pending rsp=%0d wr=%0d, required all 0",
                     busy, rsp_valid, exp_rsp.size(), exp_wr.size());
        end
    endtask

    task automatic do_reset();
        int n = 0, wl;
        clr = 0; req_valid = 0;
        exp_wr.delete(); exp_rsp.delete();
        tick(2);
`ifdef CLEAR_ON_RESET_EN
        chk_wr = 0;
        wl = wr_log.size();
        @(negedge clk); clr = 1;
        tick(2);
        n_checks++;
        if (req_ready !== 0 || busy !== 1) begin
            n_fail++;
            $display("FAIL init_flags: req_ready=%b busy=%b, required 0 1", req_ready, busy);
        end
        while (busy && n < 40) begin tick(); n++; end
        n_checks++;
        if (wr_log.size() - wl != 8) begin
            n_fail++;
            $display("FAIL init_count: %0d writes, required 8", wr_log.size() - wl);
        end else for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (wr_log[wl+i] !== {3'(i), 32'h0}) begin
                n_fail++;
                $display("FAIL init_write: got %h, required %h", wr_log[wl+i], {3'(i), 32'h0});
            end
        end
        chk_wr = 1;
        for (int i = 0; i < 8; i++) ref_mem[i] = 0;
`else
        @(negedge clk); clr = 1;
        tick();
        for (int i = 0; i < 8; i++) ref_mem[i] = rf_mem[i];
`endif
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++;
`ifdef CLEAR_ON_RESET_EN
        if (req_ready !== 0 || busy !== 1) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b busy=%b, required 0 1", req_ready, busy);
        end
`else
        if (req_ready !== 1 || busy !== 0) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b busy=%b, required 1 0", req_ready, busy);
        end
`endif
        n_checks++;
        if ({rsp_valid, rf_ce, rsp_addr, rsp_rdata, rf_addr, rf_di} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rsp_valid=%b rf_ce=%b rsp=%h/%h rf=%h/%h, required all 0",
                     rsp_valid, rf_ce, rsp_addr, rsp_rdata, rf_addr, rf_di);
        end
        do_reset();
    endtask

    task automatic test_basic();
        rsp_ready = 1;
        send(1, 3, 32'hDEADBEEF);
        tick();
        n_checks++;
        if (rf_ce !== 1 || rf_addr !== 3 || rf_di !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_strobe: ce=%b addr=%0d di=%h, required 1 3 deadbeef", rf_ce, rf_addr, rf_di);
        end
        tick();
        n_checks++;
        if (rf_ce !== 0 || rf_mem[3] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_single: ce=%b mem3=%h, required 0 deadbeef", rf_ce, rf_mem[3]);
        end
        send(0, 3, 0);
        tick();
        n_checks++;
        if (rsp_valid !== 0 || rf_ce !== 0 || rf_addr !== 3) begin
            n_fail++;
            $display("FAIL rd_issue: rsp_valid=%b ce=%b addr=%0d, required 0 0 3", rsp_valid, rf_ce, rf_addr);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1 || rsp_addr !== 3 || rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_resp: valid=%b addr=%0d data=%h, required 1 3 deadbeef", rsp_valid, rsp_addr, rsp_rdata);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int b = wr_cyc.size();
        for (int i = 0; i < 8; i++) send(1, 3'(i), $urandom);
        drain();
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (wr_cyc.size() < b + 8 || wr_cyc[b+i] - wr_cyc[b+i-1] != 2) begin
                n_fail++;
                $display("FAIL wr_spacing: write %0d gap=%0d, required 2", i,
                         wr_cyc.size() >= b + 8 ? wr_cyc[b+i] - wr_cyc[b+i-1] : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        int base = rcv.size();
        logic [34:0] v;
        rsp_ready = 0;
        for (int i = 0; i < 5; i++) send(0, 3'($urandom_range(0, 7)), 0);
        n_checks++;
        if (req_ready !== 0 || busy !== 1 || rsp_valid !== 1) begin
            n_fail++;
            $display("FAIL fifo_full: req_ready=%b busy=%b rsp_valid=%b, required 0 1 1", req_ready, busy, rsp_valid);
        end
        v = {rsp_addr, rsp_rdata};
        repeat (4) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1 || {rsp_addr, rsp_rdata} !== v || req_ready !== 0) begin
                n_fail++;
                $display("FAIL rsp_stable: valid=%b %h ready=%b, required 1 %h 0", rsp_valid, {rsp_addr, rsp_rdata}, req_ready, v);
            end
        end
        drain();
        n_checks++;
        if (rcv.size() - base != 5 || req_ready !== 1) begin
            n_fail++;
            $display("FAIL rsp_count: %0d responses ready=%b, required 5 1", rcv.size() - base, req_ready);
        end
    endtask

    task automatic test_wrap();
        int base = rcv.size();
        for (int i = 0; i < 8; i++) send(1, 3'(i), 32'(i + 1));
        for (int i = 0; i < 8; i++) send(0, 3'(i), 0);
        drain();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rcv.size() < base + 8 || rcv[base+i] !== {3'(i), 32'(i + 1)}) begin
                n_fail++;
                $display("FAIL wrap_read: index %0d got %h, required %h", i,
                         rcv.size() > base + i ? rcv[base+i] : 35'h0, {3'(i), 32'(i + 1)});
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, wl;
        logic [31:0] old = ref_mem[5];
        rsp_ready = 0;
        send(0, 1, 0);
        for (int i = 0; i < 4; i++) send(1, 5, old ^ 32'(i + 1));
        rsp_ready = 1;
        while (!rf_ce && n < 50) begin tick(); n++; end
        n_checks++;
        if (rf_ce !== 1 || busy !== 1) begin
            n_fail++;
            $display("FAIL mid_setup: ce=%b busy=%b, required 1 1", rf_ce, busy);
        end
        clr = 0;
        #1;
        n_checks++;
        if (rf_ce !== 0 || busy !== 0 || rsp_valid !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: ce=%b busy=%b rsp_valid=%b, required 0 0 0", rf_ce, busy, rsp_valid);
        end
        tick();
        n_checks++;
        if (rf_mem[5] !== old) begin
            n_fail++;
            $display("FAIL mid_no_commit: mem5=%h, required %h", rf_mem[5], old);
        end
        do_reset();
        wl = wr_log.size();
        tick(10);
        n_checks++;
        if (wr_log.size() != wl || busy !== 0) begin
            n_fail++;
            $display("FAIL mid_quiet: %0d writes busy=%b, required 0 0", wr_log.size() - wl, busy);
        end
    endtask

    task automatic test_clear_on_reset();
        int base;
        send(1, 7, 32'h55);
        drain();
        do_reset();
        base = rcv.size();
        send(0, 7, 0);
        drain();
        n_checks++;
`ifdef CLEAR_ON_RESET_EN
        if (rcv.size() <= base || rcv[base] !== {3'd7, 32'h0}) begin
            n_fail++;
            $display("FAIL clear_read: got %h, required %h", rcv.size() > base ? rcv[base] : 35'h0, {3'd7, 32'h0});
        end
`else
        if (rcv.size() <= base || rcv[base] !== {3'd7, 32'h55}) begin
            n_fail++;
            $display("FAIL clear_read: got %h, required %h", rcv.size() > base ? rcv[base] : 35'h0, {3'd7, 32'h55});
        end
`endif
    endtask

    task automatic test_random();
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
        end
        rand_rdy = 0;
        drain();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rf_mem[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL mem_final: reg %0d got %h, required %h", i, rf_mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] <= 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_clear_on_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
